bullet_ctrl: RTL and testbench
==============================

BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 SHALL have parameter FIRE_KEY, default 8'h2C, USB keycode that fires.
REQ-002 SHALL have parameter COOLDOWN, default 15, frames between accepted shots.
REQ-003 SHALL have parameter BULLET_LIFE, default 300, movement frames before a bullet expires.
REQ-004 SHALL have parameters X_MIN=0, X_MAX=639, Y_MIN=0, Y_MAX=479, the arena bounds in pixels.
REQ-005 SHALL have port frame_clk, input, 1 bit: the single clock, one edge per video frame.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port keycode, input, 32 bits: four concurrent key bytes.
REQ-008 SHALL have ports TankX and TankY, inputs, 10 bits each: tank centre in pixels.
REQ-009 SHALL have port Angle, input, 5 bits: tank heading index 0..21, counter-clockwise, 360/22 degrees per step.
REQ-010 SHALL have ports BulletX and BulletY, outputs, 40 bits each: slot i is at bits [10i+9:10i].
REQ-011 SHALL have port BulletActive, output, 4 bits: bit i high while slot i is in flight.
REQ-012 SHALL have port Fired, output, 1 bit: one-frame pulse on each accepted shot.

Function
REQ-013 SHALL detect fire_req when any keycode byte equals FIRE_KEY.
REQ-014 SHALL register fire_req into fire_prev every frame; a shot is requested only on the edge where fire_req=1 and fire_prev=0.
REQ-015 SHALL accept a requested shot only when cooldown=0 and at least one slot is inactive; otherwise the request is dropped without queuing.
REQ-016 SHALL allocate the lowest-index inactive slot on an accepted shot.
REQ-017 SHALL, on acceptance, load the slot with X=TankX and Y=TankY, velocity (dx,dy)=LUT[Angle], life=BULLET_LIFE, and active=1; Fired=1 and cooldown=COOLDOWN that same edge.
REQ-018 SHALL implement the direction LUT as dx=round(3*cos(2*pi*a/22)) and dy=-round(3*sin(2*pi*a/22)), each a signed 3-bit value; Angle>=22 SHALL be treated as 0.
REQ-019 SHALL decrement cooldown by 1 per frame while it is nonzero, saturating at 0.
REQ-020 SHALL leave a newly spawned slot unmoved on its spawn edge; movement starts on the next edge.
REQ-021 SHALL, per active slot per frame, compute nx=X+dx and ny=Y+dy in 11-bit signed arithmetic.
REQ-022 SHALL, when nx<X_MIN or nx>X_MAX, negate dx and hold X; otherwise X<=nx. The Y axis SHALL follow the same rule independently with ny, dy and Y.
REQ-023 SHALL decrement a slot's life by 1 each movement frame; when life equals 1 at an edge, the slot SHALL clear to active=0 at that edge.
REQ-024 SHALL have an expiring slot free for allocation only from the following frame, not on its expiry edge.
REQ-025 SHALL hold an inactive slot's X/Y/velocity at their last values; they are don't-care for the renderer.
REQ-026 SHALL make Fired a registered output, high for exactly one frame per accepted shot.
REQ-027 SHALL make all state updates synchronous to frame_clk; there SHALL be no combinational path from keycode to outputs.

Reset
REQ-028 SHALL, on Reset=1 at a frame_clk edge, clear BulletActive to 0, all X/Y/dx/dy/life to 0, cooldown to 0, fire_prev to 0, and Fired to 0.
REQ-029 SHALL let Reset override all other activity, including an in-flight bullet or a fire edge in the same frame.

Verification
REQ-030 SHALL verify reset: assert Reset for 1 edge -> BulletActive=4'b0000, BulletX=0, BulletY=0, Fired=0.
REQ-031 SHALL verify a basic shot: Angle=0, Tank=(300,250), keycode[7:0]=8'h2C for one edge -> Active=4'b0001, X0=300, Y0=250, Fired=1; after 10 more edges X0=330, Y0=250.
REQ-032 SHALL verify edge detect and cooldown: hold key 40 frames -> exactly one shot; release and re-press at frame 5 after the shot -> dropped; re-press after frame 15 -> slot 1 fires.
REQ-033 SHALL verify wall bounce: Angle=11 (dx=-3, dy=0), TankX=5, fire -> X0 sequence 5,2,2,5,8.
REQ-034 SHALL verify pool full and expiry: fire 4 shots spaced by cooldown -> Active=4'b1111; 5th press -> Fired=0; slot 0 clears after 300 movement frames and the next press reuses slot 0.
REQ-035 SHALL verify mid-flight reset: two bullets active, then Reset -> next edge Active=0000; a fire edge in the same frame is ignored.

Source files
------------

// File: rtl/bullet_ctrl.sv
// Four-slot bullet pool for a tank game: edge-triggered firing with cooldown,
// per-frame movement with wall bounce, and lifetime expiry.
module bullet_ctrl #(
    parameter logic [7:0] FIRE_KEY    = 8'h2C,
    parameter int         COOLDOWN    = 15,
    parameter int         BULLET_LIFE = 300,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 639,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 479
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic [9:0]  TankX,
    input  logic [9:0]  TankY,
    input  logic [4:0]  Angle,
    output logic [39:0] BulletX,
    output logic [39:0] BulletY,
    output logic [3:0]  BulletActive,
    output logic        Fired
);
    localparam int NSLOT  = 4;
    localparam int CD_W   = $clog2(COOLDOWN + 2);
    localparam int LIFE_W = $clog2(BULLET_LIFE + 2);
    localparam logic signed [10:0] X_LO = 11'(X_MIN);
    localparam logic signed [10:0] X_HI = 11'(X_MAX);
    localparam logic signed [10:0] Y_LO = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI = 11'(Y_MAX);

    logic [3:0]        key_hit;
    logic              fire_req;
    logic              shot_req;
    logic              accept;
    logic              any_free;
    logic [1:0]        alloc_idx;
    logic              fire_prev_reg;
    logic [CD_W-1:0]   cooldown_reg;
    logic              fired_reg;
    logic [NSLOT-1:0]  active_vec;
    logic signed [2:0] lut_dx;
    logic signed [2:0] lut_dy;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            assign key_hit[gi] = (keycode[8*gi +: 8] == FIRE_KEY);
        end
    endgenerate

    assign fire_req = |key_hit;
    assign shot_req = fire_req & ~fire_prev_reg;

    // Lowest-index free slot wins; the scan runs high-to-low so the last hit is the lowest.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = 2'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!active_vec[i]) begin
                any_free  = 1'b1;
                alloc_idx = 2'(i);
            end
        end
    end

    assign accept = shot_req && (cooldown_reg == '0) && any_free;

    // Speed-3 direction table, 22 headings counter-clockwise; screen Y grows downward.
    always_comb begin
        {lut_dx, lut_dy} = {3'sd3, 3'sd0};
        case (Angle)
            5'd1:  {lut_dx, lut_dy} = {3'sd3, -3'sd1};
            5'd2:  {lut_dx, lut_dy} = {3'sd3, -3'sd2};
            5'd3:  {lut_dx, lut_dy} = {3'sd2, -3'sd2};
            5'd4:  {lut_dx, lut_dy} = {3'sd1, -3'sd3};
            5'd5:  {lut_dx, lut_dy} = {3'sd0, -3'sd3};
            5'd6:  {lut_dx, lut_dy} = {3'sd0, -3'sd3};
            5'd7:  {lut_dx, lut_dy} = {-3'sd1, -3'sd3};
            5'd8:  {lut_dx, lut_dy} = {-3'sd2, -3'sd2};
            5'd9:  {lut_dx, lut_dy} = {-3'sd3, -3'sd2};
            5'd10: {lut_dx, lut_dy} = {-3'sd3, -3'sd1};
            5'd11: {lut_dx, lut_dy} = {-3'sd3, 3'sd0};
            5'd12: {lut_dx, lut_dy} = {-3'sd3, 3'sd1};
            5'd13: {lut_dx, lut_dy} = {-3'sd3, 3'sd2};
            5'd14: {lut_dx, lut_dy} = {-3'sd2, 3'sd2};
            5'd15: {lut_dx, lut_dy} = {-3'sd1, 3'sd3};
            5'd16: {lut_dx, lut_dy} = {3'sd0, 3'sd3};
            5'd17: {lut_dx, lut_dy} = {3'sd0, 3'sd3};
            5'd18: {lut_dx, lut_dy} = {3'sd1, 3'sd3};
            5'd19: {lut_dx, lut_dy} = {3'sd2, 3'sd2};
            5'd20: {lut_dx, lut_dy} = {3'sd3, 3'sd2};
            5'd21: {lut_dx, lut_dy} = {3'sd3, 3'sd1};
            default: {lut_dx, lut_dy} = {3'sd3, 3'sd0};
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            fire_prev_reg <= 1'b0;
            cooldown_reg  <= '0;
            fired_reg     <= 1'b0;
        end else begin
            fire_prev_reg <= fire_req;
            fired_reg     <= accept;
            if (accept)
                cooldown_reg <= CD_W'(COOLDOWN);
            else if (cooldown_reg != '0)
                cooldown_reg <= cooldown_reg - CD_W'(1);
        end
    end

    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [9:0]        x_reg;
            logic [9:0]        y_reg;
            logic signed [2:0] dx_reg;
            logic signed [2:0] dy_reg;
            logic [LIFE_W-1:0] life_reg;
            logic              active_reg;
            logic signed [10:0] nx;
            logic signed [10:0] ny;
            logic              load;

            assign load = accept && (alloc_idx == 2'(gi));
            assign nx   = $signed({1'b0, x_reg}) + $signed({{8{dx_reg[2]}}, dx_reg});
            assign ny   = $signed({1'b0, y_reg}) + $signed({{8{dy_reg[2]}}, dy_reg});

            // A bounce reverses velocity and keeps the old coordinate for that frame.
            always_ff @(posedge frame_clk) begin
                if (Reset) begin
                    x_reg      <= '0;
                    y_reg      <= '0;
                    dx_reg     <= '0;
                    dy_reg     <= '0;
                    life_reg   <= '0;
                    active_reg <= 1'b0;
                end else if (load) begin
                    x_reg      <= TankX;
                    y_reg      <= TankY;
                    dx_reg     <= lut_dx;
                    dy_reg     <= lut_dy;
                    life_reg   <= LIFE_W'(BULLET_LIFE);
                    active_reg <= 1'b1;
                end else if (active_reg) begin
                    if (nx < X_LO || nx > X_HI)
                        dx_reg <= -dx_reg;
                    else
                        x_reg <= nx[9:0];
                    if (ny < Y_LO || ny > Y_HI)
                        dy_reg <= -dy_reg;
                    else
                        y_reg <= ny[9:0];
                    life_reg <= life_reg - LIFE_W'(1);
                    if (life_reg == LIFE_W'(1))
                        active_reg <= 1'b0;
                end
            end

            assign active_vec[gi]       = active_reg;
            assign BulletX[10*gi +: 10] = x_reg;
            assign BulletY[10*gi +: 10] = y_reg;
        end
    endgenerate

    assign BulletActive = active_vec;
    assign Fired        = fired_reg;
endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: trigonometric reference model checked every frame,
// plus directed scenarios with literal expectations.
module tb_bullet_ctrl;
    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic [9:0]  TankX;
    logic [9:0]  TankY;
    logic [4:0]  Angle;
    logic [39:0] BulletX;
    logic [39:0] BulletY;
    logic [3:0]  BulletActive;
    logic        Fired;

    bullet_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .TankX       (TankX),
        .TankY       (TankY),
        .Angle       (Angle),
        .BulletX     (BulletX),
        .BulletY     (BulletY),
        .BulletActive(BulletActive),
        .Fired       (Fired)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fired_cnt = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int m_x[4], m_y[4], m_dx[4], m_dy[4], m_life[4];
    bit m_act[4];
    int m_cd = 0;
    bit m_prev = 0;
    bit m_fired = 0;
    bit m_req, m_shot, m_acc;
    int m_free, m_nx, m_ny;

    function automatic int rnd(real r);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    function automatic int dir_x(int a);
        real th;
        if (a >= 22) a = 0;
        th = 2.0 * 3.14159265358979 * a / 22.0;
        return rnd(3.0 * $cos(th));
    endfunction

    function automatic int dir_y(int a);
        real th;
        if (a >= 22) a = 0;
        th = 2.0 * 3.14159265358979 * a / 22.0;
        return -rnd(3.0 * $sin(th));
    endfunction

    initial for (int i = 0; i < 4; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_life[i] = 0; m_act[i] = 0;
    end

    always @(posedge frame_clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_life[i] = 0; m_act[i] = 0;
            end
            m_cd = 0; m_prev = 0; m_fired = 0;
        end else begin
            m_req = 0;
            for (int b = 0; b < 4; b++) if (keycode[8*b +: 8] == 8'h2C) m_req = 1;
            m_shot = m_req && !m_prev;
            m_prev = m_req;
            m_free = -1;
            for (int i = 3; i >= 0; i--) if (!m_act[i]) m_free = i;
            m_acc = m_shot && (m_cd == 0) && (m_free >= 0);
            for (int i = 0; i < 4; i++) begin
                if (m_act[i]) begin
                    m_nx = m_x[i] + m_dx[i];
                    m_ny = m_y[i] + m_dy[i];
                    if (m_nx < 0 || m_nx > 639) m_dx[i] = -m_dx[i]; else m_x[i] = m_nx;
                    if (m_ny < 0 || m_ny > 479) m_dy[i] = -m_dy[i]; else m_y[i] = m_ny;
                    m_life[i]--;
                    if (m_life[i] == 0) m_act[i] = 0;
                end
            end
            if (m_acc) begin
                m_x[m_free] = TankX; m_y[m_free] = TankY;
                m_dx[m_free] = dir_x(Angle); m_dy[m_free] = dir_y(Angle);
                m_life[m_free] = 300; m_act[m_free] = 1;
            end
            if (m_acc) m_cd = 15; else if (m_cd > 0) m_cd--;
            m_fired = m_acc;
        end
    end

    // Every-frame comparison against the model, away from the active edge.
    always @(negedge frame_clk) begin
        if (chk_en) begin
            chk("model_active", 40'(BulletActive), 40'({m_act[3], m_act[2], m_act[1], m_act[0]}));
            chk("model_fired", 40'(Fired), 40'(m_fired));
            for (int i = 0; i < 4; i++) begin
                if (m_act[i]) begin
                    chk("model_x", 40'(BulletX[10*i +: 10]), 40'(m_x[i]));
                    chk("model_y", 40'(BulletY[10*i +: 10]), 40'(m_y[i]));
                end
            end
            if (Fired === 1'b1) fired_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge frame_clk);
        #1;
        cyc++;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    localparam logic [31:0] KEY0 = 32'h0000_002C;
    int s0, fc0;
    int bounce_exp[4] = '{2, 2, 5, 8};
    int pool_ang[4] = '{0, 5, 13, 25};

    initial begin
        Reset = 1'b1; keycode = '0; TankX = 10'd300; TankY = 10'd250; Angle = 5'd0;

        // reset state
        tick();
        chk("reset_active", 40'(BulletActive), 40'd0);
        chk("reset_x", BulletX, 40'd0);
        chk("reset_y", BulletY, 40'd0);
        chk("reset_fired", 40'(Fired), 40'd0);
        chk_en = 1;
        Reset = 1'b0;

        // basic shot
        keycode = KEY0;
        tick();
        chk("shot_active", 40'(BulletActive), 40'd1);
        chk("shot_x0", 40'(BulletX[9:0]), 40'd300);
        chk("shot_y0", 40'(BulletY[9:0]), 40'd250);
        chk("shot_fired", 40'(Fired), 40'd1);
        keycode = '0;
        step(10);
        chk("move_x0", 40'(BulletX[9:0]), 40'd330);
        chk("move_y0", 40'(BulletY[9:0]), 40'd250);

        // held key fires once
        do_reset();
        fc0 = fired_cnt;
        keycode = 32'h2C00_0000;
        step(40);
        chk("hold_shots", 40'(fired_cnt - fc0), 40'd1);
        chk("hold_active", 40'(BulletActive), 40'd1);
        keycode = '0;

        // cooldown: re-press at +5 and +15 dropped, +17 accepted into slot 1
        do_reset();
        keycode = 32'h0000_2C00;
        tick();
        chk("cd_first", 40'(Fired), 40'd1);
        keycode = '0;
        step(4);
        keycode = KEY0;
        tick();
        chk("cd_plus5_fired", 40'(Fired), 40'd0);
        chk("cd_plus5_active", 40'(BulletActive), 40'd1);
        keycode = '0;
        step(9);
        keycode = KEY0;
        tick();
        chk("cd_plus15_fired", 40'(Fired), 40'd0);
        keycode = '0;
        tick();
        keycode = KEY0;
        tick();
        chk("cd_plus17_fired", 40'(Fired), 40'd1);
        chk("cd_plus17_active", 40'(BulletActive), 40'd3);
        keycode = '0;

        // wall bounce at the left edge
        do_reset();
        Angle = 5'd11; TankX = 10'd5; TankY = 10'd100;
        keycode = KEY0;
        tick();
        chk("bounce_x0_0", 40'(BulletX[9:0]), 40'd5);
        keycode = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bounce_x0", 40'(BulletX[9:0]), 40'(bounce_exp[k]));
            chk("bounce_y0", 40'(BulletY[9:0]), 40'd100);
        end

        // direction table sweep, including out-of-range headings
        TankX = 10'd320; TankY = 10'd240;
        for (int a = 0; a < 32; a++) begin
            do_reset();
            Angle = 5'(a);
            keycode = KEY0;
            tick();
            keycode = '0;
            step(2);
        end

        // pool full, expiry and slot reuse
        do_reset();
        TankX = 10'd300; TankY = 10'd250;
        for (int k = 0; k < 4; k++) begin
            Angle = 5'(pool_ang[k]);
            keycode = KEY0;
            tick();
            if (k == 0) s0 = cyc;
            keycode = '0;
            step(16);
        end
        chk("pool_full", 40'(BulletActive), 40'd15);
        keycode = KEY0;
        tick();
        chk("pool_full_fired", 40'(Fired), 40'd0);
        chk("pool_full_active", 40'(BulletActive), 40'd15);
        keycode = '0;
        while (cyc < s0 + 299) tick();
        chk("pre_expiry_active", 40'(BulletActive), 40'd15);
        keycode = KEY0;
        tick();
        chk("expiry_edge_fired", 40'(Fired), 40'd0);
        chk("expiry_edge_active", 40'(BulletActive), 40'd14);
        keycode = '0;
        tick();
        keycode = KEY0;
        tick();
        chk("reuse_fired", 40'(Fired), 40'd1);
        chk("reuse_active", 40'(BulletActive), 40'd15);
        chk("reuse_x0", 40'(BulletX[9:0]), 40'd300);
        keycode = '0;

        // mid-flight reset overrides a simultaneous fire edge
        do_reset();
        Angle = 5'd3;
        keycode = KEY0;
        tick();
        keycode = '0;
        step(16);
        keycode = KEY0;
        tick();
        keycode = '0;
        tick();
        chk("mid_two_active", 40'(BulletActive), 40'd3);
        Reset = 1'b1;
        keycode = KEY0;
        tick();
        chk("mid_reset_active", 40'(BulletActive), 40'd0);
        chk("mid_reset_fired", 40'(Fired), 40'd0);
        chk("mid_reset_x", BulletX, 40'd0);
        Reset = 1'b0;
        keycode = '0;
        tick();
        chk("post_reset_active", 40'(BulletActive), 40'd0);
        chk("post_reset_fired", 40'(Fired), 40'd0);

        @(negedge frame_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
